// File: rtl/i2c_bus_arbiter.sv
// Two-client round-robin arbiter in front of one i2c_master; one whole transaction per grant.
// Optional START/RUN watchdog is built when I2C_ARB_TIMEOUT_EN is defined.
module i2c_bus_arbiter
`ifdef I2C_ARB_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535
)
`endif
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [7:0] req0_nbytes,
  input  logic [6:0] req0_addr,
  input  logic       req0_rw,
  input  logic [7:0] req0_wdata,
  input  logic [7:0] req1_nbytes,
  input  logic [6:0] req1_addr,
  input  logic       req1_rw,
  input  logic [7:0] req1_wdata,
  output logic [1:0] grant,
  output logic [1:0] done,
  output logic [1:0] tx_data_req_o,
  output logic [1:0] rx_data_ready_o,
  output logic [7:0] read_data_o,
  output logic       m_start,
  output logic [7:0] m_nbytes,
  output logic [6:0] m_addr,
  output logic       m_rw,
  output logic [7:0] m_write_data,
  input  logic [7:0] m_read_data,
  input  logic       m_tx_data_req,
  input  logic       m_rx_data_ready,
  input  logic       m_ready,
  input  logic       m_busy,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_r;
  logic       rr_r;        // 1 = client 1 wins a tie
  logic [1:0] pick_s;
  logic       tmo_s;

  // Winner among current requesters, tie broken by the round-robin pointer.
  always_comb begin
    pick_s = 2'b00;
    case (req)
      2'b01:   pick_s = 2'b01;
      2'b10:   pick_s = 2'b10;
      2'b11:   pick_s = rr_r ? 2'b10 : 2'b01;
      default: pick_s = 2'b00;
    endcase
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] cnt_r;
  logic        timeout_err_r;

  assign tmo_s       = (cnt_r == TMO_LAST);
  assign timeout_err = timeout_err_r;

  // Watchdog: held at zero while idle, counts every START/RUN clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r         <= 32'd0;
      timeout_err_r <= 1'b0;
    end else begin
      timeout_err_r <= 1'b0;
      if (state_r == IDLE) begin
        cnt_r <= 32'd0;
      end else if ((state_r == START) || (state_r == RUN)) begin
        cnt_r <= cnt_r + 32'd1;
        if (tmo_s) begin
          timeout_err_r <= 1'b1;
        end
      end
    end
  end
`else
  assign tmo_s       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Ownership FSM; done, grant and m_start are all registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      grant   <= 2'b00;
      done    <= 2'b00;
      m_start <= 1'b0;
      rr_r    <= 1'b0;
    end else begin
      done <= 2'b00;
      case (state_r)
        IDLE: begin
          if (m_ready && (req != 2'b00)) begin
            grant   <= pick_s;
            state_r <= START;
          end
        end
        START: begin
          if (tmo_s) begin
            done    <= grant;
            grant   <= 2'b00;
            m_start <= 1'b0;
            rr_r    <= grant[0];
            state_r <= DONE;
          end else if (m_busy) begin
            m_start <= 1'b0;
            state_r <= RUN;
          end else begin
            m_start <= 1'b1;
          end
        end
        RUN: begin
          if (tmo_s || (!m_busy && m_ready)) begin
            done    <= grant;
            grant   <= 2'b00;
            m_start <= 1'b0;
            rr_r    <= grant[0];
            state_r <= DONE;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          grant   <= 2'b00;
          m_start <= 1'b0;
        end
      endcase
    end
  end

  // Command mux from the registered owner; all zero when the bus is free.
  always_comb begin
    m_nbytes     = 8'h00;
    m_addr       = 7'h00;
    m_rw         = 1'b0;
    m_write_data = 8'h00;
    case (grant)
      2'b01: begin
        m_nbytes     = req0_nbytes;
        m_addr       = req0_addr;
        m_rw         = req0_rw;
        m_write_data = req0_wdata;
      end
      2'b10: begin
        m_nbytes     = req1_nbytes;
        m_addr       = req1_addr;
        m_rw         = req1_rw;
        m_write_data = req1_wdata;
      end
      default: begin
        m_nbytes     = 8'h00;
        m_addr       = 7'h00;
        m_rw         = 1'b0;
        m_write_data = 8'h00;
      end
    endcase
  end

  assign tx_data_req_o   = grant & {2{m_tx_data_req}};
  assign rx_data_ready_o = grant & {2{m_rx_data_ready}};
  assign read_data_o     = m_read_data;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter: directed sequences, a vector table for the
// owner-gated handshakes, and randomized traffic against a transaction-level model.
module tb_i2c_bus_arbiter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [1:0] req;
  logic [7:0] req0_nbytes, req0_wdata, req1_nbytes, req1_wdata;
  logic [6:0] req0_addr, req1_addr;
  logic       req0_rw, req1_rw;
  logic [1:0] grant, done, tx_data_req_o, rx_data_ready_o;
  logic [7:0] read_data_o, m_nbytes, m_write_data, m_read_data;
  logic [6:0] m_addr;
  logic       m_start, m_rw, m_tx_data_req, m_rx_data_ready, m_ready, m_busy, timeout_err;

`ifdef I2C_ARB_TIMEOUT_EN
  i2c_bus_arbiter #(.TIMEOUT_CYCLES(100)) dut (
`else
  i2c_bus_arbiter dut (
`endif
    .clk(clk), .reset(reset), .req(req),
    .req0_nbytes(req0_nbytes), .req0_addr(req0_addr), .req0_rw(req0_rw), .req0_wdata(req0_wdata),
    .req1_nbytes(req1_nbytes), .req1_addr(req1_addr), .req1_rw(req1_rw), .req1_wdata(req1_wdata),
    .grant(grant), .done(done), .tx_data_req_o(tx_data_req_o), .rx_data_ready_o(rx_data_ready_o),
    .read_data_o(read_data_o), .m_start(m_start), .m_nbytes(m_nbytes), .m_addr(m_addr),
    .m_rw(m_rw), .m_write_data(m_write_data), .m_read_data(m_read_data),
    .m_tx_data_req(m_tx_data_req), .m_rx_data_ready(m_rx_data_ready),
    .m_ready(m_ready), .m_busy(m_busy), .timeout_err(timeout_err)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1; req = 2'b00; m_busy = 1'b0; m_ready = 1'b1;
    m_tx_data_req = 1'b0; m_rx_data_ready = 1'b0; m_read_data = 8'h00;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  // Master completes the command already started by the owner.
  task automatic run_xfer(input logic [1:0] own, input string nm);
    m_busy = 1'b1; m_ready = 1'b0;
    cyc(); cyc();
    m_busy = 1'b0; m_ready = 1'b1;
    cyc(); smp();
    chk(nm, done, own);
  endtask

  // Reference arbitration rule: lone requester wins, tie goes to whoever was not served last.
  function automatic logic [1:0] pick(input logic [1:0] r, input logic last_owner);
    if (r == 2'b11) return last_owner ? 2'b01 : 2'b10;
    return r;
  endfunction

  // Behavioural i2c_master: answers m_start after a short delay, stays busy a few clocks.
  bit mm_en = 1'b0;
  bit mm_jitter = 1'b0;
  initial begin
    forever begin
      cyc();
      if (mm_en && m_start && !m_busy) begin
        repeat ($urandom_range(0, 2)) cyc();
        m_busy = 1'b1; m_ready = 1'b0;
        repeat ($urandom_range(1, 8)) cyc();
        m_busy = 1'b0; m_ready = 1'b1;
      end else if (mm_en && !m_busy) begin
        m_ready = mm_jitter ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Transaction-level monitor: every cycle compares owner and command against the model.
  bit         mon_en = 1'b0;
  bit         mon_primed = 1'b0;
  logic       mon_last = 1'b1;
  logic [1:0] pg, pd, preq, eg;
  logic       pready, pbusy;
  int         served[2];
  initial begin
    forever begin
      smp();
      if (mon_en) begin
        if (mon_primed) begin
          if (pg == 2'b00) begin
            eg = ((pd == 2'b00) && pready) ? pick(preq, mon_last) : 2'b00;
            chk("mon_grant", grant, eg);
            if (eg != 2'b00) served[eg[1]]++;
          end else if (grant == 2'b00) begin
            chk("mon_done_owner", done, pg);
            chk("mon_end_cond", {pbusy, pready}, 2'b01);
            mon_last = pg[1];
          end else begin
            chk("mon_hold", {grant, done}, {pg, 2'b00});
          end
          chk("mon_cmd", {m_addr, m_nbytes, m_rw},
              (grant == 2'b01) ? {req0_addr, req0_nbytes, req0_rw} :
              (grant == 2'b10) ? {req1_addr, req1_nbytes, req1_rw} : 16'h0000);
        end
        pg = grant; pd = done; preq = req; pready = m_ready; pbusy = m_busy;
        mon_primed = 1'b1;
      end else begin
        mon_primed = 1'b0;
      end
    end
  end

  typedef struct {
    logic       tx, rx;
    logic [7:0] rd, w0, w1;
    logic [1:0] e_tx, e_rx;
    logic [7:0] e_rd, e_wd;
  } vec_t;
  vec_t vecs[4];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] gseq[4];
    int         ng, cycle, last_done;
    bit         flag;

    vecs[0] = '{1'b1, 1'b1, 8'hA5, 8'hC3, 8'h3C, 2'b10, 2'b10, 8'hA5, 8'h3C};
    vecs[1] = '{1'b1, 1'b0, 8'h00, 8'hFF, 8'h11, 2'b10, 2'b00, 8'h00, 8'h11};
    vecs[2] = '{1'b0, 1'b1, 8'h5A, 8'h01, 8'h22, 2'b00, 2'b10, 8'h5A, 8'h22};
    vecs[3] = '{1'b0, 1'b0, 8'hFF, 8'h80, 8'h80, 2'b00, 2'b00, 8'hFF, 8'h80};

    req0_nbytes = 8'd0; req0_addr = 7'h00; req0_rw = 1'b0; req0_wdata = 8'h00;
    req1_nbytes = 8'd0; req1_addr = 7'h00; req1_rw = 1'b0; req1_wdata = 8'h00;

    // T1: single client 0 read transaction
    apply_reset();
    smp();
    chk("rst_grant", grant, 2'b00);
    chk("rst_done", done, 2'b00);
    chk("rst_start", m_start, 1'b0);
    chk("rst_tmo", timeout_err, 1'b0);
    chk("rst_cmd", {m_addr, m_nbytes, m_rw, m_write_data}, 24'h000000);
    req0_addr = 7'h55; req0_nbytes = 8'd2; req0_rw = 1'b1; req0_wdata = 8'h12; req = 2'b01;
    cyc(); smp();
    chk("t1_grant", grant, 2'b01);
    chk("t1_start_lat", m_start, 1'b0);
    cyc(); smp();
    chk("t1_start", m_start, 1'b1);
    chk("t1_addr", m_addr, 7'h55);
    chk("t1_nbytes", m_nbytes, 8'd2);
    chk("t1_rw", m_rw, 1'b1);
    cyc(); smp();
    chk("t1_start_hold", m_start, 1'b1);
    m_busy = 1'b1; m_ready = 1'b0;
    cyc(); smp();
    chk("t1_start_drop", m_start, 1'b0);
    chk("t1_grant_run", grant, 2'b01);
    repeat (3) cyc();
    m_busy = 1'b0; m_ready = 1'b1;
    cyc(); smp();
    chk("t1_done", done, 2'b01);
    chk("t1_free", grant, 2'b00);
    chk("t1_cmd_zero", m_addr, 7'h00);
    req = 2'b00;
    cyc(); smp();
    chk("t1_done_pulse", done, 2'b00);

    // T3: handshakes gated to client 1 only
    m_tx_data_req = 1'b1; m_rx_data_ready = 1'b1; m_read_data = 8'h3C;
    #1;
    chk("t3_free_tx", tx_data_req_o, 2'b00);
    chk("t3_free_rx", rx_data_ready_o, 2'b00);
    chk("t3_bcast", read_data_o, 8'h3C);
    m_tx_data_req = 1'b0; m_rx_data_ready = 1'b0;
    req1_addr = 7'h2A; req1_nbytes = 8'd4; req1_rw = 1'b0; req = 2'b10;
    cyc(); smp();
    chk("t3_grant", grant, 2'b10);
    for (int i = 0; i < 4; i++) begin
      m_tx_data_req = vecs[i].tx; m_rx_data_ready = vecs[i].rx; m_read_data = vecs[i].rd;
      req0_wdata = vecs[i].w0; req1_wdata = vecs[i].w1;
      #1;
      chk($sformatf("t3_tx[%0d]", i), tx_data_req_o, vecs[i].e_tx);
      chk($sformatf("t3_rx[%0d]", i), rx_data_ready_o, vecs[i].e_rx);
      chk($sformatf("t3_rd[%0d]", i), read_data_o, vecs[i].e_rd);
      chk($sformatf("t3_wd[%0d]", i), m_write_data, vecs[i].e_wd);
      chk($sformatf("t3_addr[%0d]", i), m_addr, 7'h2A);
    end
    m_tx_data_req = 1'b0; m_rx_data_ready = 1'b0;
    run_xfer(2'b10, "t3_done");
    req = 2'b00;
    cyc();

    // T4: no grant while the master is not ready
    m_ready = 1'b0; req = 2'b01;
    for (int i = 0; i < 20; i++) begin
      cyc(); smp();
      chk("t4_no_grant", grant, 2'b00);
    end
    m_ready = 1'b1;
    cyc(); smp();
    chk("t4_grant", grant, 2'b01);
    run_xfer(2'b01, "t4_done");
    req = 2'b00;
    cyc();

    // T2: both requesting, round robin from reset
    apply_reset();
    req0_addr = 7'h11; req1_addr = 7'h22;
    served[0] = 0; served[1] = 0; mon_last = 1'b1; mon_en = 1'b1;
    mm_jitter = 1'b0; mm_en = 1'b1; req = 2'b11;
    ng = 0; cycle = 0; last_done = -1; flag = 1'b0;
    while (ng < 4 && cycle < 400) begin
      cyc(); smp(); cycle++;
      if (grant != 2'b00 && !flag) begin
        gseq[ng] = grant; ng++;
        if (last_done >= 0) chk("t2_gap", (cycle - last_done) <= 3, 1'b1);
      end
      flag = (grant != 2'b00);
      if (done != 2'b00) last_done = cycle;
    end
    chk("t2_count", ng, 4);
    chk("t2_seq", {gseq[0], gseq[1], gseq[2], gseq[3]}, 8'b01_10_01_10);

    // Random traffic, clients drop or keep req after their done
    mm_jitter = 1'b1;
    for (int i = 0; i < 600; i++) begin
      cyc();
      for (int c = 0; c < 2; c++) begin
        if (!req[c]) begin
          if ($urandom_range(0, 3) == 0) begin
            if (c == 0) begin
              req0_addr = 7'($urandom); req0_nbytes = 8'($urandom); req0_rw = 1'($urandom);
            end else begin
              req1_addr = 7'($urandom); req1_nbytes = 8'($urandom); req1_rw = 1'($urandom);
            end
            req[c] = 1'b1;
          end
        end else if (done[c] && $urandom_range(0, 1) == 1) begin
          req[c] = 1'b0;
        end
      end
    end
    req = 2'b00;
    flag = 1'b0;
    for (int i = 0; i < 200 && !flag; i++) begin
      cyc(); smp();
      flag = (grant == 2'b00) && (done == 2'b00) && !m_busy && !m_start;
    end
    chk("rand_drain", flag, 1'b1);
    cyc();
    mon_en = 1'b0; mm_en = 1'b0;
    chk("rand_c0_served", served[0] > 2, 1'b1);
    chk("rand_c1_served", served[1] > 2, 1'b1);

    // T5: master stuck busy
    apply_reset();
    req0_addr = 7'h33; req = 2'b01;
    cyc(); smp();
    chk("t5_grant", grant, 2'b01);
    m_busy = 1'b1; m_ready = 1'b0;
    flag = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
    for (int i = 0; i < 99; i++) begin
      cyc(); smp();
      if (timeout_err || done != 2'b00 || grant != 2'b01) flag = 1'b1;
    end
    chk("t5_no_early", flag, 1'b0);
    cyc(); smp();
    chk("t5_tmo", timeout_err, 1'b1);
    chk("t5_done", done, 2'b01);
    chk("t5_free", grant, 2'b00);
    req = 2'b00;
    cyc(); smp();
    chk("t5_tmo_pulse", timeout_err, 1'b0);
`else
    for (int i = 0; i < 200; i++) begin
      cyc(); smp();
      if (timeout_err || done != 2'b00 || grant != 2'b01) flag = 1'b1;
    end
    chk("t5_held", flag, 1'b0);
    chk("t5_still_owned", grant, 2'b01);
`endif
    m_busy = 1'b0; m_ready = 1'b1; req = 2'b00;

    // T6: reset in RUN, then round robin restarts at client 0
    apply_reset();
    req = 2'b01;
    cyc(); smp();
    chk("t6_grant_a", grant, 2'b01);
    run_xfer(2'b01, "t6_done_a");
    cyc(); cyc(); smp();
    chk("t6_grant_b", grant, 2'b01);
    cyc(); smp();
    chk("t6_start", m_start, 1'b1);
    m_busy = 1'b1; m_ready = 1'b0;
    cyc(); smp();
    chk("t6_in_run", {m_start, grant}, 3'b0_01);
    reset = 1'b1;
    cyc(); smp();
    chk("t6_rst_grant", grant, 2'b00);
    chk("t6_rst_start", m_start, 1'b0);
    chk("t6_rst_done", done, 2'b00);
    cyc(); smp();
    chk("t6_rst_done2", done, 2'b00);
    reset = 1'b0; m_busy = 1'b0; m_ready = 1'b1; req = 2'b11;
    cyc(); smp();
    chk("t6_rr_reset", grant, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
